// File: rtl/data_memory_pipelined.sv
// Single-port synchronous data RAM behind a valid/ready request port.
// Zero-fill sweep after reset and on clr_req; 1- or 2-cycle read latency.
module data_memory_pipelined #(
    parameter int WORD_SIZE  = 19,
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_req,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [WORD_SIZE-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_INIT, S_RUN, S_CLEAR} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic                 sweeping, accept, in_range, mem_we;
    logic [IDX_W-1:0]     mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [WORD_SIZE-1:0] rd_raw_q;
    logic [WORD_SIZE-1:0] s1_rdata;
    logic                 ok_q;
    logic [RD_LATENCY:1]  vld_pipe, err_pipe;

    assign sweeping  = (state_q != S_RUN);
    assign busy      = sweeping;
    // clr_req wins over a same-cycle request, so the port is closed that cycle
    assign req_ready = (state_q == S_RUN) && !clr_req;
    assign accept    = req_valid && req_ready;
    assign in_range  = ({1'b0, req_addr} < (ADDR_W+1)'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_INIT, S_CLEAR: begin
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        mem_we    = sweeping || (accept && req_we && in_range);
        mem_addr  = sweeping ? cnt_q : req_addr[IDX_W-1:0];
        mem_wdata = sweeping ? '0 : req_wdata;
    end

    // Array and raw read register carry no reset so they map onto block RAM
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
        if (accept && !req_we)
            rd_raw_q <= mem[req_addr[IDX_W-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            err_pipe <= '0;
            ok_q     <= 1'b0;
        end else begin
            vld_pipe <= RD_LATENCY'({vld_pipe, accept});
            err_pipe <= RD_LATENCY'({err_pipe, accept && !in_range});
            ok_q     <= accept && !req_we && in_range;
        end
    end

    // Writes and errored reads return zero; idle cycles hold zero too
    assign s1_rdata = ok_q ? rd_raw_q : '0;

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [WORD_SIZE-1:0] rdata2_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) rdata2_q <= '0;
                else        rdata2_q <= s1_rdata;
            end
            assign rsp_rdata = rdata2_q;
        end else begin : g_lat1
            assign rsp_rdata = s1_rdata;
        end
    endgenerate

    assign rsp_valid = vld_pipe[RD_LATENCY];
    assign rsp_err   = err_pipe[RD_LATENCY];

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Two instances (1024 deep / latency 1 and 1000 deep / latency 2) share stimulus
// and are checked against a queue-based transaction model.
module tb_data_memory_pipelined;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr_req = 1'b0, req_valid = 1'b0, req_we = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [18:0] req_wdata = '0;
    logic        rdy [2];
    logic        rv  [2];
    logic        re  [2];
    logic        bz  [2];
    logic [18:0] rd  [2];

    always #5 clk = ~clk;

    data_memory_pipelined #(.WORD_SIZE(19), .DEPTH(1024), .ADDR_W(10), .RD_LATENCY(1)) u_a (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[0]),
        .rsp_rdata(rd[0]), .rsp_err(re[0]), .busy(bz[0]));

    data_memory_pipelined #(.WORD_SIZE(19), .DEPTH(1000), .ADDR_W(10), .RD_LATENCY(2)) u_b (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[1]),
        .rsp_rdata(rd[1]), .rsp_err(re[1]), .busy(bz[1]));

    typedef struct {int due; logic [18:0] d; logic e;} rsp_t;
    rsp_t        qa[$], qb[$];
    logic [18:0] mm [2][1024];
    int          sweep_left [2];
    int          cyc = 0, checks = 0, errors = 0;
    logic        ev [2], ee [2];
    logic [18:0] ed [2];

    function automatic int dep(int k); return (k == 0) ? 1024 : 1000; endfunction
    function automatic int lat(int k); return (k == 0) ? 1 : 2; endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            sweep_left[k] = dep(k);
            for (int a = 0; a < 1024; a++) mm[k][a] = '0;
        end
        qa.delete();
        qb.delete();
    endtask

    task automatic set_req(input bit v, input bit we, input int a, input logic [18:0] d);
        req_valid = v; req_we = we; req_addr = a[9:0]; req_wdata = d;
    endtask

    // Apply the current inputs to the model, advance one clock, and pop due responses.
    task automatic tick();
        rsp_t r;
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (sweep_left[k] > 0) sweep_left[k]--;
                else if (clr_req) begin
                    sweep_left[k] = dep(k);
                    for (int a = 0; a < 1024; a++) mm[k][a] = '0;
                end else if (req_valid) begin
                    r.due = cyc + lat(k);
                    r.e   = (int'(req_addr) >= dep(k));
                    r.d   = '0;
                    if (!r.e) begin
                        if (req_we) mm[k][req_addr] = req_wdata;
                        else        r.d = mm[k][req_addr];
                    end
                    if (k == 0) qa.push_back(r); else qb.push_back(r);
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int k = 0; k < 2; k++) begin ev[k] = 1'b0; ee[k] = 1'b0; ed[k] = '0; end
        if (qa.size() > 0 && qa[0].due == cyc) begin
            r = qa.pop_front(); ev[0] = 1'b1; ed[0] = r.d; ee[0] = r.e;
        end
        if (qb.size() > 0 && qb[0].due == cyc) begin
            r = qb.pop_front(); ev[1] = 1'b1; ed[1] = r.d; ee[1] = r.e;
        end
    endtask

    // Ticks until each instance drops busy; -1 if it never does.
    task automatic wait_sweep(output int na, output int nb);
        na = -1; nb = -1;
        for (int i = 1; i <= 1100; i++) begin
            tick();
            if (na < 0 && bz[0] === 1'b0) na = i;
            if (nb < 0 && bz[1] === 1'b0) nb = i;
            if (na >= 0 && nb >= 0) break;
        end
    endtask

    task automatic test_reset();
        int na, nb;
        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({rv[k], re[k], rd[k], rdy[k], bz[k]} !== {1'b0, 1'b0, 19'h0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got v%b e%b d%h rdy%b busy%b, want 0 0 0 0 1",
                         k, rv[k], re[k], rd[k], rdy[k], bz[k]);
            end
        end
        model_reset();
        set_req(0, 0, 0, 0);
        tick(); tick();
        rst_n = 1'b1;
        wait_sweep(na, nb);
        checks++;
        if (na != 1024 || nb != 1000) begin
            errors++; $display("FAIL init_sweep_len: got %0d/%0d, want 1024/1000", na, nb);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rdy[k] !== 1'b1) begin errors++; $display("FAIL ready_after_init dut%0d: got %b want 1", k, rdy[k]); end
        end
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_req(1, 0, 0, 0);
                1: set_req(1, 0, 1023, 0);
                default: set_req(0, 0, 0, 0);
            endcase
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rv[k] !== ev[k] || re[k] !== ee[k] || rd[k] !== ed[k]) begin
                    errors++;
                    $display("FAIL reset_reads dut%0d cyc %0d: got v%b e%b d%h want v%b e%b d%h",
                             k, cyc, rv[k], re[k], rd[k], ev[k], ee[k], ed[k]);
                end
            end
            if (i == 2) begin
                checks++;
                if (rv[1] !== 1'b1 || re[1] !== 1'b1 || rd[1] !== 19'h0) begin
                    errors++; $display("FAIL b_read1023_err: got v%b e%b d%h want 1 1 0", rv[1], re[1], rd[1]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_req(1, 1, 5, 19'h7FFFF);
                1: set_req(1, 0, 5, 0);
                default: set_req(0, 0, 0, 0);
            endcase
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rv[k] !== ev[k] || re[k] !== ee[k] || rd[k] !== ed[k]) begin
                    errors++;
                    $display("FAIL write_read dut%0d cyc %0d: got v%b e%b d%h want v%b e%b d%h",
                             k, cyc, rv[k], re[k], rd[k], ev[k], ee[k], ed[k]);
                end
            end
            if (i == 1 || i == 2) begin
                checks++;
                if (rv[i-1] !== 1'b1 || rd[i-1] !== 19'h7FFFF) begin
                    errors++; $display("FAIL latency dut%0d: got v%b d%h want 1 7ffff", i - 1, rv[i-1], rd[i-1]);
                end
            end
        end
    endtask

    task automatic test_range();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: set_req(1, 1, 1000, 19'h12345);
                1: set_req(1, 0, 1000, 0);
                2: set_req(1, 0, 0, 0);
                3: set_req(1, 0, 1023, 0);
                default: set_req(0, 0, 0, 0);
            endcase
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rv[k] !== ev[k] || re[k] !== ee[k] || rd[k] !== ed[k]) begin
                    errors++;
                    $display("FAIL range dut%0d cyc %0d: got v%b e%b d%h want v%b e%b d%h",
                             k, cyc, rv[k], re[k], rd[k], ev[k], ee[k], ed[k]);
                end
            end
            if (i == 1) begin
                checks++;
                if (rv[0] !== 1'b1 || re[0] !== 1'b0 || rd[0] !== 19'h12345) begin
                    errors++; $display("FAIL a_read1000: got v%b e%b d%h want 1 0 12345", rv[0], re[0], rd[0]);
                end
            end
            if (i == 2 || i == 3) begin
                checks++;
                if (rv[1] !== 1'b1 || re[1] !== (i == 2) || rd[1] !== 19'h0) begin
                    errors++; $display("FAIL b_nowrap step%0d: got v%b e%b d%h want e%0d d0", i, rv[1], re[1], rd[1], i == 2);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            if (i < 3)      set_req(1, 1, i + 1, 19'(i + 1));
            else if (i < 6) set_req(1, 0, i - 2, 0);
            else            set_req(0, 0, 0, 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rv[k] !== ev[k] || re[k] !== ee[k] || rd[k] !== ed[k]) begin
                    errors++;
                    $display("FAIL back_to_back dut%0d cyc %0d: got v%b e%b d%h want v%b e%b d%h",
                             k, cyc, rv[k], re[k], rd[k], ev[k], ee[k], ed[k]);
                end
            end
            if (i >= 3 && i <= 5) begin
                checks++;
                if (rv[0] !== 1'b1 || rd[0] !== 19'(i - 2)) begin
                    errors++; $display("FAIL b2b_order step%0d: got v%b d%h want 1 %h", i, rv[0], rd[0], i - 2);
                end
            end
        end
    endtask

    task automatic test_clear();
        int na, nb;
        set_req(1, 1, 5, 19'h7FFFF); tick();
        set_req(1, 0, 5, 0);         tick();
        checks++;
        if (rv[0] !== 1'b1 || rd[0] !== 19'h7FFFF) begin
            errors++; $display("FAIL clear_inflight_a: got v%b d%h want 1 7ffff", rv[0], rd[0]);
        end
        clr_req = 1'b1;
        set_req(1, 1, 5, 19'h1);
        tick();
        clr_req = 1'b0;
        set_req(0, 0, 0, 0);
        checks++;
        if (rv[1] !== 1'b1 || rd[1] !== 19'h7FFFF || bz[0] !== 1'b1 || bz[1] !== 1'b1) begin
            errors++; $display("FAIL clear_inflight_b: got v%b d%h busy%b%b want 1 7ffff 11", rv[1], rd[1], bz[0], bz[1]);
        end
        wait_sweep(na, nb);
        checks++;
        if (na != 1024 || nb != 1000) begin
            errors++; $display("FAIL clear_sweep_len: got %0d/%0d, want 1024/1000", na, nb);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 0) set_req(1, 0, 5, 0); else set_req(0, 0, 0, 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rv[k] !== ev[k] || re[k] !== ee[k] || rd[k] !== ed[k]) begin
                    errors++;
                    $display("FAIL after_clear dut%0d cyc %0d: got v%b e%b d%h want v%b e%b d%h",
                             k, cyc, rv[k], re[k], rd[k], ev[k], ee[k], ed[k]);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        int na, nb;
        set_req(1, 0, 1, 0); tick();
        set_req(1, 0, 2, 0); tick();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({rv[k], re[k], rd[k], bz[k]} !== {1'b0, 1'b0, 19'h0, 1'b1}) begin
                errors++; $display("FAIL reset_midflight dut%0d: got v%b e%b d%h busy%b", k, rv[k], re[k], rd[k], bz[k]);
            end
        end
        model_reset();
        set_req(0, 0, 0, 0);
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rv[k] !== 1'b0) begin errors++; $display("FAIL no_rsp_in_reset dut%0d: got %b want 0", k, rv[k]); end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bz[k] !== 1'b1 || rdy[k] !== 1'b0) begin
                errors++; $display("FAIL reset_midsweep dut%0d: got busy%b rdy%b want 1 0", k, bz[k], rdy[k]);
            end
        end
        model_reset();
        tick();
        rst_n = 1'b1;
        wait_sweep(na, nb);
        checks++;
        if (na != 1024 || nb != 1000) begin
            errors++; $display("FAIL resweep_len: got %0d/%0d, want 1024/1000", na, nb);
        end
    endtask

    task automatic test_random();
        bit cleared = 1'b0;
        int a;
        for (int i = 0; i < 600; i++) begin
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 15);
            set_req($urandom_range(0, 9) < 7, $urandom_range(0, 1), a, 19'($urandom));
            clr_req = (!cleared && i > 200 && $urandom_range(0, 99) == 0);
            if (clr_req) cleared = 1'b1;
            tick();
            clr_req = 1'b0;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rv[k] !== ev[k] || re[k] !== ee[k] || rd[k] !== ed[k] || bz[k] !== (sweep_left[k] > 0)) begin
                    errors++;
                    $display("FAIL random dut%0d cyc %0d: got v%b e%b d%h busy%b want v%b e%b d%h busy%b",
                             k, cyc, rv[k], re[k], rd[k], bz[k], ev[k], ee[k], ed[k], sweep_left[k] > 0);
                end
            end
        end
        set_req(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_range();
        test_back_to_back();
        test_clear();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
